// File: rtl/vector_pkg.sv
// rtl/vector_pkg.sv - shared state type and sizing constants for the pixel scheduler.
package vector_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } sched_state_t;

   // Widest coordinate the raster counters compare against.
   localparam int PIX_CNT_W = 16;

   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - x-fastest raster position counter that wraps at the screen bounds.
module raster_counter
   import vector_pkg::*;
#(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       enable,
   output logic [$clog2(WIDTH)-1:0]   x,
   output logic [$clog2(HEIGHT)-1:0]  y,
   output logic                       last
);
   localparam logic [PIX_CNT_W-1:0] X_END = PIX_CNT_W'(WIDTH - 1);
   localparam logic [PIX_CNT_W-1:0] Y_END = PIX_CNT_W'(HEIGHT - 1);

   logic x_end;

   assign x_end = (PIX_CNT_W'(x) == X_END);
   assign last  = x_end && (PIX_CNT_W'(y) == Y_END);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x <= '0;
         y <= '0;
      end else if (clear) begin
         x <= '0;
         y <= '0;
      end else if (enable) begin
         if (x_end) begin
            x <= '0;
            y <= last ? '0 : y + 1'b1;
         end else begin
            x <= x + 1'b1;
         end
      end
   end

endmodule

// File: rtl/pixel_scheduler.sv
// rtl/pixel_scheduler.sv - raster-order pixel dispatch to ray-march cores with in-order result collection.
module pixel_scheduler
   import vector_pkg::*;
#(
   parameter int SCREEN_WIDTH  = 640,
   parameter int SCREEN_HEIGHT = 480,
   parameter int NUM_CORES     = 4,
   parameter int OUT_WIDTH     = 24
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               start,
   output logic [$clog2(SCREEN_WIDTH)-1:0]    req_x,
   output logic [$clog2(SCREEN_HEIGHT)-1:0]   req_y,
   output logic [NUM_CORES-1:0]               req_valid,
   input  logic [NUM_CORES-1:0]               req_ready,
   input  logic [NUM_CORES-1:0]               res_valid,
   input  logic [NUM_CORES*OUT_WIDTH-1:0]     res_shade,
   output logic [NUM_CORES-1:0]               res_ready,
   output logic [OUT_WIDTH-1:0]               shade_out,
   output logic                               valid_out,
   output logic                               sof,
   output logic                               eol,
   input  logic                               ready,
   output logic                               busy,
   output logic                               frame_done
);
   localparam int XW = $clog2(SCREEN_WIDTH);
   localparam int YW = $clog2(SCREEN_HEIGHT);
   localparam int PW = ptr_w(NUM_CORES);
   localparam logic [PW-1:0] PTR_LAST = PW'(NUM_CORES - 1);

   sched_state_t   state;
   logic [PW-1:0]  disp_ptr;
   logic [PW-1:0]  coll_ptr;
   logic [XW-1:0]  out_x;
   logic [YW-1:0]  out_y;
   logic           disp_last;
   logic           out_last;
   logic           out_is_last;
   logic           frame_start;
   logic           disp_fire;
   logic           res_fire;
   logic           out_fire;
   logic           out_free;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   assign busy        = (state != IDLE);
   assign frame_start = (state == IDLE) && start;
   assign disp_fire   = (state == RUN) && req_ready[disp_ptr];
   assign out_free    = !valid_out || ready;
   assign res_fire    = busy && out_free && res_valid[coll_ptr];
   assign out_fire    = valid_out && ready;

   assign req_valid = (state == RUN) ? (NUM_CORES'(1) << disp_ptr) : '0;
   assign res_ready = (busy && out_free) ? (NUM_CORES'(1) << coll_ptr) : '0;

   raster_counter #(
      .WIDTH  (SCREEN_WIDTH),
      .HEIGHT (SCREEN_HEIGHT)
   ) disp_cnt (
      .clk    (clk),
      .rst    (rst),
      .clear  (frame_start),
      .enable (disp_fire),
      .x      (req_x),
      .y      (req_y),
      .last   (disp_last)
   );

   // Tracks the position of the next result to be loaded into the output register.
   raster_counter #(
      .WIDTH  (SCREEN_WIDTH),
      .HEIGHT (SCREEN_HEIGHT)
   ) out_cnt (
      .clk    (clk),
      .rst    (rst),
      .clear  (frame_start),
      .enable (res_fire),
      .x      (out_x),
      .y      (out_y),
      .last   (out_last)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         disp_ptr    <= '0;
         coll_ptr    <= '0;
         shade_out   <= '0;
         valid_out   <= 1'b0;
         sof         <= 1'b0;
         eol         <= 1'b0;
         out_is_last <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE:    if (start) state <= RUN;
            RUN:     if (disp_fire && disp_last) state <= DRAIN;
            DRAIN: begin
               if (out_fire && out_is_last) begin
                  state      <= IDLE;
                  frame_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

         if (frame_start) begin
            disp_ptr <= '0;
         end else if (disp_fire) begin
            disp_ptr <= next_ptr(disp_ptr);
         end

         if (frame_start) begin
            coll_ptr <= '0;
         end else if (res_fire) begin
            coll_ptr <= next_ptr(coll_ptr);
         end

         if (res_fire) begin
            shade_out   <= res_shade[int'(coll_ptr) * OUT_WIDTH +: OUT_WIDTH];
            valid_out   <= 1'b1;
            sof         <= (out_x == '0) && (out_y == '0);
            eol         <= (out_x == XW'(SCREEN_WIDTH - 1));
            out_is_last <= out_last;
         end else if (out_fire) begin
            valid_out <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pixel_scheduler.sv
// tb/tb_pixel_scheduler.sv - self-checking bench for pixel_scheduler with 2-core and 1-core instances.
module tb_pixel_scheduler;
   localparam int W  = 4;
   localparam int H  = 2;
   localparam int OW = 24;
   localparam int XW = $clog2(W);
   localparam int YW = $clog2(H);

   typedef struct {
      int            pix;
      int            t;
      logic [OW-1:0] shade;
   } job_t;

   typedef struct {
      int lat0;
      int lat1;
      bit rand_core;
      int stall_at;
      int stall_len;
      int restart_at;
      int exp_outs;
      int exp_done;
      int exp_hold;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [1:0]    start_all;
   logic [1:0]    ready_all;
   logic [2:0]    req_ready_all;
   logic [2:0]    res_valid_all;
   logic [OW-1:0] shade_in [3];

   logic [XW-1:0]   a_req_x, b_req_x;
   logic [YW-1:0]   a_req_y, b_req_y;
   logic [1:0]      a_req_valid, a_res_ready;
   logic [0:0]      b_req_valid, b_res_ready;
   logic [2*OW-1:0] a_res_shade;
   logic [OW-1:0]   b_res_shade;
   logic [OW-1:0]   a_shade_out, b_shade_out;
   logic            a_valid_out, a_sof, a_eol, a_busy, a_frame_done;
   logic            b_valid_out, b_sof, b_eol, b_busy, b_frame_done;

   assign a_res_shade = {shade_in[1], shade_in[0]};
   assign b_res_shade = shade_in[2];

   pixel_scheduler #(
      .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .NUM_CORES(2), .OUT_WIDTH(OW)
   ) dut_a (
      .clk(clk), .rst(rst), .start(start_all[0]),
      .req_x(a_req_x), .req_y(a_req_y), .req_valid(a_req_valid), .req_ready(req_ready_all[1:0]),
      .res_valid(res_valid_all[1:0]), .res_shade(a_res_shade), .res_ready(a_res_ready),
      .shade_out(a_shade_out), .valid_out(a_valid_out), .sof(a_sof), .eol(a_eol),
      .ready(ready_all[0]), .busy(a_busy), .frame_done(a_frame_done)
   );

   pixel_scheduler #(
      .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .NUM_CORES(1), .OUT_WIDTH(OW)
   ) dut_b (
      .clk(clk), .rst(rst), .start(start_all[1]),
      .req_x(b_req_x), .req_y(b_req_y), .req_valid(b_req_valid), .req_ready(req_ready_all[2:2]),
      .res_valid(res_valid_all[2:2]), .res_shade(b_res_shade), .res_ready(b_res_ready),
      .shade_out(b_shade_out), .valid_out(b_valid_out), .sof(b_sof), .eol(b_eol),
      .ready(ready_all[1]), .busy(b_busy), .frame_done(b_frame_done)
   );

   wire [2:0] req_valid_all = {b_req_valid, a_req_valid};
   wire [2:0] res_ready_all = {b_res_ready, a_res_ready};
   wire [1:0] valid_v = {b_valid_out, a_valid_out};
   wire [1:0] sof_v   = {b_sof, a_sof};
   wire [1:0] eol_v   = {b_eol, a_eol};
   wire [1:0] busy_v  = {b_busy, a_busy};
   wire [1:0] done_v  = {b_frame_done, a_frame_done};
   logic [OW-1:0] shade_out_v [2];
   logic [XW-1:0] req_x_v [2];
   logic [YW-1:0] req_y_v [2];
   assign shade_out_v[0] = a_shade_out;
   assign shade_out_v[1] = b_shade_out;
   assign req_x_v[0] = a_req_x;
   assign req_x_v[1] = b_req_x;
   assign req_y_v[0] = a_req_y;
   assign req_y_v[1] = b_req_y;

   // Core slots 0,1 serve dut_a; slot 2 serves dut_b.
   job_t q [3][$];
   int   lat [3];
   bit   rnd [3];
   int   cyc;
   int   salt;
   int   disp_pix [2];
   int   out_pix [2];
   int   fd_cnt [2];
   bit   hold_seen;
   bit   prev_stall [2];
   logic [OW-1:0] prev_shade [2];
   logic prev_sof [2];
   logic prev_eol [2];
   int   n_checks;
   int   n_fail;

   function automatic logic [OW-1:0] shade_of(input int d, input int s, input int p);
      return OW'(((d + 1) << 20) | ((s & 255) << 8) | (p & 255));
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive_cores();
      for (int c = 0; c < 3; c++) begin
         req_ready_all[c] = rnd[c] ? ($urandom_range(0, 2) != 0) : 1'b1;
         res_valid_all[c] = 1'b0;
         shade_in[c]      = '0;
         if (q[c].size() > 0 && q[c][0].t <= cyc) begin
            res_valid_all[c] = rnd[c] ? ($urandom_range(0, 1) == 1) : 1'b1;
            shade_in[c]      = q[c][0].shade;
         end
      end
   endtask

   task automatic tick();
      bit   dfire [3];
      bit   rfire [3];
      job_t j;
      drive_cores();
      #1;
      for (int d = 0; d < 2; d++) begin
         if (prev_stall[d]) begin
            chk("stall_valid_hold", 32'(valid_v[d]), 1);
            chk("stall_shade_hold", 32'(shade_out_v[d]), 32'(prev_shade[d]));
            chk("stall_sof_hold", 32'(sof_v[d]), 32'(prev_sof[d]));
            chk("stall_eol_hold", 32'(eol_v[d]), 32'(prev_eol[d]));
         end
         if (valid_v[d] && !ready_all[d])
            chk("stall_res_ready", (d == 0) ? 32'(res_ready_all[1:0]) : 32'(res_ready_all[2]), 0);
         if (valid_v[d] && ready_all[d]) begin
            chk("out_shade", 32'(shade_out_v[d]), 32'(shade_of(d, salt, out_pix[d])));
            chk("out_sof", 32'(sof_v[d]), (out_pix[d] == 0) ? 1 : 0);
            chk("out_eol", 32'(eol_v[d]), (out_pix[d] % W == W - 1) ? 1 : 0);
            out_pix[d]++;
         end
         prev_stall[d] = valid_v[d] && !ready_all[d];
         prev_shade[d] = shade_out_v[d];
         prev_sof[d]   = sof_v[d];
         prev_eol[d]   = eol_v[d];
      end
      for (int c = 0; c < 3; c++) begin
         int d  = (c < 2) ? 0 : 1;
         int li = (c < 2) ? c : 0;
         dfire[c] = req_valid_all[c] && req_ready_all[c];
         rfire[c] = res_valid_all[c] && res_ready_all[c];
         if (dfire[c]) begin
            chk("disp_x", 32'(req_x_v[d]), disp_pix[d] % W);
            chk("disp_y", 32'(req_y_v[d]), disp_pix[d] / W);
            chk("disp_core", li, disp_pix[d] % ((d == 0) ? 2 : 1));
         end
      end
      if (busy_v[0] && res_valid_all[1] && !res_ready_all[1]) hold_seen = 1'b1;
      @(posedge clk);
      cyc++;
      for (int c = 0; c < 3; c++) begin
         int d = (c < 2) ? 0 : 1;
         if (dfire[c]) begin
            j.pix   = disp_pix[d];
            j.t     = cyc + lat[c] - 1;
            j.shade = shade_of(d, salt, disp_pix[d]);
            q[c].push_back(j);
            disp_pix[d]++;
         end
         if (rfire[c] && q[c].size() > 0) void'(q[c].pop_front());
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++)
         if (done_v[d]) fd_cnt[d]++;
   endtask

   task automatic start_frame(input int d);
      salt++;
      disp_pix[d]  = 0;
      out_pix[d]   = 0;
      fd_cnt[d]    = 0;
      start_all[d] = 1'b1;
      tick();
      start_all[d] = 1'b0;
   endtask

   task automatic chk_idle(input int d);
      chk("rst_busy", 32'(busy_v[d]), 0);
      chk("rst_valid_out", 32'(valid_v[d]), 0);
      chk("rst_shade_out", 32'(shade_out_v[d]), 0);
      chk("rst_frame_done", 32'(done_v[d]), 0);
      chk("rst_req_valid", (d == 0) ? 32'(a_req_valid) : 32'(b_req_valid), 0);
      chk("rst_res_ready", (d == 0) ? 32'(a_res_ready) : 32'(b_res_ready), 0);
      chk("rst_req_xy", {req_x_v[d], req_y_v[d]}, 0);
   endtask

   task automatic clear_model();
      for (int c = 0; c < 3; c++) q[c].delete();
      for (int d = 0; d < 2; d++) prev_stall[d] = 1'b0;
   endtask

   initial begin
      vec_t tbl [5];
      int   n;
      int   stall_left;

      n_checks = 0;
      n_fail   = 0;
      cyc      = 0;
      salt     = 0;
      rst      = 1'b0;
      start_all     = '0;
      ready_all     = '1;
      req_ready_all = '0;
      res_valid_all = '0;
      for (int c = 0; c < 3; c++) begin
         shade_in[c] = '0;
         lat[c]      = 1;
         rnd[c]      = 1'b0;
      end
      clear_model();

      //           lat0 lat1 rnd stall_at len restart outs done hold
      tbl[0] = '{1, 1, 1'b0, -1, 0, -1, 8, 1, 0};
      tbl[1] = '{4, 1, 1'b0, -1, 0, -1, 8, 1, 1};
      tbl[2] = '{1, 1, 1'b0,  3, 5, -1, 8, 1, -1};
      tbl[3] = '{1, 1, 1'b0, -1, 0,  3, 8, 1, -1};
      tbl[4] = '{2, 3, 1'b1,  2, 3, -1, 8, 1, -1};

      repeat (3) @(negedge clk);
      chk_idle(0);
      chk_idle(1);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         lat[0]     = tbl[i].lat0;
         lat[1]     = tbl[i].lat1;
         rnd[0]     = tbl[i].rand_core;
         rnd[1]     = tbl[i].rand_core;
         hold_seen  = 1'b0;
         stall_left = tbl[i].stall_len;
         start_frame(0);
         n = 0;
         while (busy_v[0] && n < 400) begin
            if (tbl[i].stall_at >= 0 && out_pix[0] >= tbl[i].stall_at && stall_left > 0) begin
               ready_all[0] = 1'b0;
               stall_left--;
            end else begin
               ready_all[0] = 1'b1;
            end
            start_all[0] = (n == tbl[i].restart_at);
            tick();
            n++;
         end
         start_all[0] = 1'b0;
         ready_all[0] = 1'b1;
         repeat (2) tick();
         chk("frame_end_busy", 32'(busy_v[0]), 0);
         chk("out_count", out_pix[0], tbl[i].exp_outs);
         chk("frame_done_count", fd_cnt[0], tbl[i].exp_done);
         chk("cores_drained", q[0].size() + q[1].size(), 0);
         if (tbl[i].exp_hold >= 0) chk("core1_early_hold", 32'(hold_seen), tbl[i].exp_hold);
      end

      // Reset mid-frame after three outputs, then a fresh frame must begin at (0,0).
      lat[0] = 1;
      lat[1] = 1;
      rnd[0] = 1'b0;
      rnd[1] = 1'b0;
      start_frame(0);
      n = 0;
      while (out_pix[0] < 3 && n < 100) begin
         tick();
         n++;
      end
      chk("pre_reset_outs", out_pix[0], 3);
      #2 rst = 1'b0;
      #1;
      chk_idle(0);
      clear_model();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      start_frame(0);
      n = 0;
      while (busy_v[0] && n < 400) begin
         tick();
         n++;
      end
      tick();
      chk("post_reset_busy", 32'(busy_v[0]), 0);
      chk("post_reset_outs", out_pix[0], 8);
      chk("post_reset_done", fd_cnt[0], 1);

      // Single core with random dispatch, result and output stalls.
      lat[2] = 1;
      rnd[2] = 1'b1;
      for (int f = 0; f < 2; f++) begin
         start_frame(1);
         n = 0;
         while (busy_v[1] && n < 600) begin
            ready_all[1] = ($urandom_range(0, 3) != 0);
            tick();
            n++;
         end
         ready_all[1] = 1'b1;
         tick();
         chk("one_core_busy", 32'(busy_v[1]), 0);
         chk("one_core_outs", out_pix[1], 8);
         chk("one_core_done", fd_cnt[1], 1);
         chk("one_core_drained", q[2].size(), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
